// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter with optional lock, serialising requests onto the single MMIO bus.
// Latency: strobe one cycle after the IDLE grant, ack the cycle after; one transaction per 3 cycles.
module mmio_arbiter #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_wr,
   input  logic              m1_wr,
   input  logic              m0_lock,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wr_data,
   input  logic [DATA_W-1:0] m1_wr_data,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m0_rd_data,
   output logic [DATA_W-1:0] m1_rd_data,
   output logic              mmio_cs,
   output logic              mmio_wr,
   output logic              mmio_rd,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [DATA_W-1:0] mmio_wr_data,
   input  logic [DATA_W-1:0] mmio_rd_data
);

   typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;

   state_t              state_q;
   logic                owner_q;
   logic                prio_q;
   logic                lock_q;
   logic                lock_bit_q;
   logic                cs_q, wr_q, rd_q;
   logic                ack0_q, ack1_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rd0_q, rd1_q;

   logic                lock_hit;
   logic                grant_d;

   // A held lock only matters while its owner keeps requesting; otherwise round-robin decides.
   always_comb begin
      lock_hit = lock_q && (owner_q ? m1_req : m0_req);
      grant_d  = m1_req;
      if (lock_hit)
         grant_d = owner_q;
      else if (m0_req && m1_req)
         grant_d = prio_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         prio_q     <= 1'b0;
         lock_q     <= 1'b0;
         lock_bit_q <= 1'b0;
         cs_q       <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd0_q      <= '0;
         rd1_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!lock_hit)
                  lock_q <= 1'b0;
               if (m0_req || m1_req) begin
                  owner_q    <= grant_d;
                  prio_q     <= ~grant_d;
                  addr_q     <= grant_d ? m1_addr    : m0_addr;
                  wdata_q    <= grant_d ? m1_wr_data : m0_wr_data;
                  lock_bit_q <= grant_d ? m1_lock    : m0_lock;
                  wr_q       <= grant_d ? m1_wr      : m0_wr;
                  rd_q       <= grant_d ? ~m1_wr     : ~m0_wr;
                  cs_q       <= 1'b1;
                  state_q    <= BUS;
               end
            end
            BUS: begin
               cs_q <= 1'b0;
               wr_q <= 1'b0;
               rd_q <= 1'b0;
               if (rd_q) begin
                  if (owner_q)
                     rd1_q <= mmio_rd_data;
                  else
                     rd0_q <= mmio_rd_data;
               end
               ack0_q  <= ~owner_q;
               ack1_q  <= owner_q;
               lock_q  <= lock_bit_q;
               state_q <= ACK;
            end
            ACK: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mmio_cs      = cs_q;
   assign mmio_wr      = wr_q;
   assign mmio_rd      = rd_q;
   assign mmio_addr    = addr_q;
   assign mmio_wr_data = wdata_q;
   assign m0_ack       = ack0_q;
   assign m1_ack       = ack1_q;
   assign m0_rd_data   = rd0_q;
   assign m1_rd_data   = rd1_q;

endmodule
